// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the keypad BCD entry front end.
package bcd_entry_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter for a partial entry: reloads on strobes, saturates, flags expiry.
module entry_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i || load_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry fires on the idle cycle whose increment would reach the limit.
  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && !load_i && !clr_i && (count_q >= LAST);

endmodule

// File: rtl/bcd_entry_fsm.sv
// Collects up to two BCD digits and hands a left-justified word to the converter.
module bcd_entry_fsm
  import bcd_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic               enter,
  input  logic               clear,
  output logic [7:0]         bcd,
  output logic               bcd_valid,
  input  logic               bcd_ready,
  output logic               bad_digit,
  output logic               overflow,
  output logic [1:0]         digit_count
);

  state_e             state_q;
  logic [DIGIT_W-1:0] tens_q, units_q;
  logic [7:0]         bcd_q;
  logic               bcd_valid_q, bad_q, ovf_q;
  logic [1:0]         count_q;

  logic strobe, is_bad, expire, partial;

  assign digit_ready = (state_q != HOLD);
  assign strobe      = digit_valid && digit_ready;
  assign is_bad      = strobe && (digit > BCD_MAX);
  assign partial     = (state_q == ONE) || (state_q == TWO);

  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!partial),
    .load_i   (strobe),
    .en_i     (partial),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tens_q      <= '0;
      units_q     <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      bad_q <= 1'b0;
      ovf_q <= 1'b0;
      if (state_q == HOLD) begin
        if (clear || bcd_ready) begin
          state_q     <= IDLE;
          bcd_valid_q <= 1'b0;
          tens_q      <= '0;
          units_q     <= '0;
          count_q     <= '0;
        end
      end else if (clear || expire) begin
        state_q <= IDLE;
        tens_q  <= '0;
        units_q <= '0;
        count_q <= '0;
      end else if (enter && partial) begin
        // Digit registers and count stay put until the word is transferred.
        state_q     <= HOLD;
        bcd_valid_q <= 1'b1;
        bcd_q       <= (state_q == ONE) ? {{DIGIT_W{1'b0}}, units_q} : {tens_q, units_q};
      end else if (is_bad) begin
        bad_q <= 1'b1;
      end else if (strobe) begin
        case (state_q)
          IDLE: begin
            state_q <= ONE;
            units_q <= digit;
            count_q <= 2'd1;
          end
          ONE: begin
            state_q <= TWO;
            tens_q  <= units_q;
            units_q <= digit;
            count_q <= 2'd2;
          end
          default: ovf_q <= 1'b1;
        endcase
      end
    end
  end

  assign bcd         = bcd_q;
  assign bcd_valid   = bcd_valid_q;
  assign bad_digit   = bad_q;
  assign overflow    = ovf_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_bcd_entry_fsm.sv
// Directed self-checking bench for bcd_entry_fsm with a short inactivity timeout.
module tb_bcd_entry_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = 4'h0;
  logic       digit_valid = 1'b0;
  logic       digit_ready;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] bcd;
  logic       bcd_valid;
  logic       bcd_ready = 1'b1;
  logic       bad_digit;
  logic       overflow;
  logic [1:0] digit_count;

  int total = 0;
  int bad = 0;

  bcd_entry_fsm #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .enter       (enter),
    .clear       (clear),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .bad_digit   (bad_digit),
    .overflow    (overflow),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    digit_valid = 1'b0;
    enter       = 1'b0;
    clear       = 1'b0;
    digit       = 4'h0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    tick();
    quiet();
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    quiet();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bcd, bcd_valid, digit_ready, bad_digit, overflow, digit_count} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_values: got bcd=%h v=%b rdy=%b bad=%b ovf=%b cnt=%0d want bcd=00 v=0 rdy=1 bad=0 ovf=0 cnt=0",
               bcd, bcd_valid, digit_ready, bad_digit, overflow, digit_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bcd_ready = 1'b1;
    send_digit(4'd1);
    total++;
    if (digit_count !== 2'd1) begin bad++; $display("FAIL basic_cnt1: got %0d want 1", digit_count); end
    send_digit(4'd2);
    total++;
    if (digit_count !== 2'd2) begin bad++; $display("FAIL basic_cnt2: got %0d want 2", digit_count); end
    press_enter();
    total++;
    if (bcd_valid !== 1'b1 || bcd !== 8'h12) begin
      bad++; $display("FAIL basic_commit: got v=%b bcd=%h want v=1 bcd=12", bcd_valid, bcd);
    end
    tick();
    total++;
    if (bcd_valid !== 1'b0 || digit_count !== 2'd0 || digit_ready !== 1'b1) begin
      bad++; $display("FAIL basic_transfer: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", bcd_valid, digit_count, digit_ready);
    end
  endtask

  task automatic test_hold();
    bcd_ready = 1'b0;
    send_digit(4'd7);
    press_enter();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bcd_valid !== 1'b1 || bcd !== 8'h07 || digit_ready !== 1'b0 || bad_digit !== 1'b0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got v=%b bcd=%h rdy=%b bad=%b ovf=%b want v=1 bcd=07 rdy=0 bad=0 ovf=0",
                 i, bcd_valid, bcd, digit_ready, bad_digit, overflow);
      end
      digit_valid = (i == 1);
      digit       = (i == 1) ? 4'hC : 4'h3;
      bcd_ready   = (i == 5);
      tick();
    end
    quiet();
    total++;
    if (bcd_valid !== 1'b0 || digit_ready !== 1'b1 || digit_count !== 2'd0) begin
      bad++; $display("FAIL hold_release: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", bcd_valid, digit_ready, digit_count);
    end
    bcd_ready = 1'b1;
  endtask

  task automatic test_overflow();
    bcd_ready = 1'b0;
    send_digit(4'd1);
    send_digit(4'd5);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
    send_digit(4'd3);
    total++;
    if (overflow !== 1'b1 || digit_count !== 2'd2) begin
      bad++; $display("FAIL ovf_pulse: got ovf=%b cnt=%0d want ovf=1 cnt=2", overflow, digit_count);
    end
    send_digit(4'hB);
    total++;
    if (overflow !== 1'b0 || bad_digit !== 1'b1 || digit_count !== 2'd2) begin
      bad++; $display("FAIL bad_pulse: got ovf=%b bad=%b cnt=%0d want ovf=0 bad=1 cnt=2", overflow, bad_digit, digit_count);
    end
    press_enter();
    total++;
    if (bad_digit !== 1'b0 || bcd_valid !== 1'b1 || bcd !== 8'h15) begin
      bad++; $display("FAIL ovf_commit: got bad=%b v=%b bcd=%h want bad=0 v=1 bcd=15", bad_digit, bcd_valid, bcd);
    end
    bcd_ready = 1'b1;
    tick();
    send_digit(4'hF);
    total++;
    if (bad_digit !== 1'b1 || digit_count !== 2'd0) begin
      bad++; $display("FAIL bad_in_idle: got bad=%b cnt=%0d want bad=1 cnt=0", bad_digit, digit_count);
    end
  endtask

  task automatic test_simultaneous();
    bcd_ready = 1'b1;
    send_digit(4'd4);
    clear = 1'b1; enter = 1'b1; digit_valid = 1'b1; digit = 4'd5;
    tick();
    quiet();
    total++;
    if (bcd_valid !== 1'b0 || digit_count !== 2'd0 || bad_digit !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL sim_clear: got v=%b cnt=%0d bad=%b ovf=%b want v=0 cnt=0 bad=0 ovf=0",
                      bcd_valid, digit_count, bad_digit, overflow);
    end
    send_digit(4'd6);
    enter = 1'b1; digit_valid = 1'b1; digit = 4'd8;
    tick();
    quiet();
    total++;
    if (bcd_valid !== 1'b1 || bcd !== 8'h06 || digit_count !== 2'd1) begin
      bad++; $display("FAIL sim_enter: got v=%b bcd=%h cnt=%0d want v=1 bcd=06 cnt=1", bcd_valid, bcd, digit_count);
    end
    tick();
    total++;
    if (bcd_valid !== 1'b0 || digit_count !== 2'd0) begin
      bad++; $display("FAIL sim_transfer: got v=%b cnt=%0d want v=0 cnt=0", bcd_valid, digit_count);
    end
  endtask

  task automatic test_timeout();
    send_digit(4'd3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (digit_count !== 2'd1) begin bad++; $display("FAIL to_wait%0d: got cnt=%0d want 1", i, digit_count); end
    end
    tick();
    total++;
    if (digit_count !== 2'd0 || digit_ready !== 1'b1) begin
      bad++; $display("FAIL to_expire: got cnt=%0d rdy=%b want cnt=0 rdy=1", digit_count, digit_ready);
    end
    press_enter();
    total++;
    if (bcd_valid !== 1'b0) begin bad++; $display("FAIL to_enter_idle: got v=%b want 0", bcd_valid); end
    send_digit(4'd3);
    tick();
    tick();
    send_digit(4'd5);
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (digit_count !== 2'd2) begin bad++; $display("FAIL to_reload%0d: got cnt=%0d want 2", i, digit_count); end
    end
    tick();
    total++;
    if (digit_count !== 2'd0) begin bad++; $display("FAIL to_reload_expire: got cnt=%0d want 0", digit_count); end
  endtask

  task automatic test_reset_hold();
    bcd_ready = 1'b0;
    send_digit(4'd4);
    send_digit(4'd2);
    press_enter();
    total++;
    if (bcd_valid !== 1'b1 || bcd !== 8'h42) begin
      bad++; $display("FAIL rst_pre: got v=%b bcd=%h want v=1 bcd=42", bcd_valid, bcd);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (bcd_valid !== 1'b0 || bcd !== 8'h00 || digit_count !== 2'd0 || digit_ready !== 1'b1) begin
      bad++; $display("FAIL rst_async: got v=%b bcd=%h cnt=%0d rdy=%b want v=0 bcd=00 cnt=0 rdy=1",
                      bcd_valid, bcd, digit_count, digit_ready);
    end
    #2 rst = 1'b0;
    bcd_ready = 1'b1;
    send_digit(4'd9);
    press_enter();
    total++;
    if (bcd_valid !== 1'b1 || bcd !== 8'h09) begin
      bad++; $display("FAIL rst_after: got v=%b bcd=%h want v=1 bcd=09", bcd_valid, bcd);
    end
    tick();
    total++;
    if (bcd_valid !== 1'b0 || digit_count !== 2'd0) begin
      bad++; $display("FAIL rst_after_xfer: got v=%b cnt=%0d want v=0 cnt=0", bcd_valid, digit_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_simultaneous();
    test_timeout();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_entry_fsm.md
# bcd_entry_fsm

Sequential front end for the BCD-to-binary converter. Collects up to two BCD digits one at a time from a keypad-style source, left-justifies them into a two-digit BCD word (tens in [7:4], units in [3:0]), and presents that word with a valid/ready handshake directly to the combinational BCD-to-binary stage. Handles digit rejection, overflow, clear, and inactivity timeout; range checking (value ≤ 15) stays in the downstream converter.

## Interface
- TIMEOUT_CYCLES, 1000: idle cycles in a partial entry before it is discarded; 0 disables the timeout.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- digit  input  4  BCD digit from the keypad, sampled when digit_valid is high and digit_ready is high.
- digit_valid  input  1  single-cycle strobe marking a new digit.
- digit_ready  output  1  high when a digit can be accepted (not in HOLD).
- enter  input  1  strobe; commits the current entry.
- clear  input  1  strobe; discards the current entry.
- bcd  output  8  committed word to the converter; stable while bcd_valid is high.
- bcd_valid  output  1  committed word available.
- bcd_ready  input  1  downstream accepts bcd this cycle.
- bad_digit  output  1  one-cycle pulse when an offered digit > 9 was dropped.
- overflow  output  1  one-cycle pulse when a third digit was dropped.
- digit_count  output  2  digits currently held (0..2).

## Operation
- States: IDLE (0 digits), ONE (1 digit), TWO (2 digits), HOLD (word committed, awaiting bcd_ready).
- Per-cycle event priority: clear > enter > digit.
- clear in IDLE/ONE/TWO: go to IDLE and zero the digit registers. clear in HOLD: drop bcd_valid, go to IDLE, and do not transfer the word.
- Digit accepted (digit_valid && digit_ready && digit ≤ 9):
  - IDLE→ONE: units = digit.
  - ONE→TWO: tens = old units; units = digit.
  - TWO: digit dropped, overflow pulses, state unchanged.
- digit > 9 with digit_valid: dropped in any non-HOLD state; bad_digit pulses. This check takes precedence over overflow.
- digit_valid in HOLD: ignored silently (digit_ready is low). No pulses.
- enter in ONE: bcd = {4'h0, units}. enter in TWO: bcd = {tens, units}. Both go to HOLD. enter in IDLE or HOLD: ignored.
- HOLD: when bcd_valid && bcd_ready, go to IDLE. Digit registers and digit_count clear on the same edge.
- Timeout: the counter reloads on every accepted or rejected digit strobe. In ONE/TWO with no strobe, the counter increments. On reaching TIMEOUT_CYCLES, the FSM goes to IDLE as if clear had occurred. The counter is held at 0 in IDLE/HOLD.
- Clear, enter, and timeout produce no pulse outputs.

## Timing
- Reset values: state IDLE, bcd 8'h00, bcd_valid 0, digit_ready 1, bad_digit 0, overflow 0, digit_count 0, timer 0.
- All outputs are registered except digit_ready, which is decoded from state (state != HOLD).
- Latency:
  - enter on cycle N → bcd_valid high from cycle N+1.
  - Transfer on cycle M → bcd_valid low and digit_ready high from cycle M+1.
  - Back-to-back entries need at least one cycle in IDLE after transfer.
- bad_digit and overflow are high exactly the cycle after the offending strobe.
- digit_count updates the cycle after the event.
- Reset mid-entry or mid-HOLD: immediate return to reset values. A word that was never handshaked is lost.
- Timer width is $clog2(TIMEOUT_CYCLES+1), minimum 1. The timer must not wrap: it saturates at the timeout.

## Structure
- Package bcd_entry_pkg:
  - state enum (IDLE, ONE, TWO, HOLD);
  - BCD_MAX = 4'd9;
  - DIGIT_W = 4.
- Sub-module entry_timer: load/enable/expire counter, parameterised by TIMEOUT_CYCLES. Ties expire to 0 when TIMEOUT_CYCLES is 0.
- The top level contains the FSM, the digit registers, and the pulse registers.

## Test plan
- Digits 1, 2 then enter, bcd_ready held high → bcd = 8'h12 and bcd_valid for exactly 1 cycle; digit_count sequence 1, 2, 0.
- Digit 7, enter, bcd_ready low for 5 cycles → bcd = 8'h07 held stable for 6 cycles; digit_valid during HOLD ignored with no pulses.
- Digits 1, 5, 3 → overflow pulses once; enter gives 8'h15. Digit 4'hB → bad_digit pulses and digit_count is unchanged.
- Simultaneous events:
  - clear + enter + digit in the same cycle in ONE → IDLE, no bcd_valid;
  - enter + digit in ONE → commit 8'h0d with the old digit, new digit dropped.
- TIMEOUT_CYCLES=4: digit 3, then 4 idle cycles → IDLE and digit_count 0. With a strobe on cycle 3, no timeout occurs.
- rst asserted mid-HOLD (asynchronously, off-edge) → bcd_valid, bcd, and digit_count drop to 0 immediately; the subsequent entry of 9 then enter works normally.
